// File: rtl/vanilla_pending_tracker_pkg.sv
// Shared types and helpers for the vanilla pending-operation tracker.
// Category enum values double as indices into the per-register pending vectors.
package vanilla_pending_tracker_pkg;

  localparam int num_pending_cat_gp = 7;
  localparam int vanilla_pending_lat_width_gp = 16;

  typedef enum logic [2:0] {
    e_pcat_long_div      = 3'd0,
    e_pcat_dram          = 3'd1,
    e_pcat_global        = 3'd2,
    e_pcat_group         = 3'd3,
    e_pcat_amo_dram      = 3'd4,
    e_pcat_amo_group     = 3'd5,
    e_pcat_dmem_overflow = 3'd6
  } vanilla_pending_cat_e;

  typedef struct packed {
    logic [num_pending_cat_gp-1:0]           pending;
    logic [vanilla_pending_lat_width_gp-1:0] lat;
  } vanilla_pending_entry_s;

  // Address width that never collapses to zero bits for single-entry structures.
  function automatic int safeClog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold a count from 0 up to and including n.
  function automatic int bsgWidth(input int n);
    return safeClog2(n + 1);
  endfunction

endpackage

// File: rtl/vanilla_pending_reg_entry.sv
// One tracked register: its per-category pending bits, a saturating latency
// counter, and the per-cycle set/clear/error events the top level aggregates.
// A same-cycle clear is applied before the issue so the new category survives.
module vanilla_pending_reg_entry
  import vanilla_pending_tracker_pkg::*;
#(
  parameter int num_cat_p    = num_pending_cat_gp,
  parameter int lat_width_p  = 16,
  parameter int cat_width_lp = safeClog2(num_cat_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    issue_i,
  input  logic [cat_width_lp-1:0] issueCat_i,
  input  logic                    clear_i,
  output logic [num_cat_p-1:0]    pending_o,
  output logic                    busy_o,
  output logic [num_cat_p-1:0]    removed_o,
  output logic [num_cat_p-1:0]    added_o,
  output logic                    retire_o,
  output logic [lat_width_p-1:0]  retireLat_o,
  output logic                    errDoubleIssue_o,
  output logic                    errClearIdle_o
);

  localparam logic [lat_width_p-1:0] LatMax = '1;

  logic [num_cat_p-1:0]   pending_q;
  logic [num_cat_p-1:0]   pending_d;
  logic [num_cat_p-1:0]   issueMask;
  logic [num_cat_p-1:0]   afterClear;
  logic [lat_width_p-1:0] lat_q;
  logic [lat_width_p-1:0] lat_d;

  assign pending_o = pending_q;
  assign busy_o    = |pending_q;

  // Decode the issued category into a one-hot mask; out-of-range categories set nothing.
  always_comb begin
    issueMask = '0;
    for (int c = 0; c < num_cat_p; c++) begin
      if (issue_i && (int'(issueCat_i) == c)) begin
        issueMask[c] = 1'b1;
      end
    end
  end

  // Clear retires every category first, then the issue bit lands on the cleaned state.
  always_comb begin
    removed_o  = clear_i ? pending_q : '0;
    afterClear = pending_q & ~removed_o;
    added_o    = issueMask & ~afterClear;
    pending_d  = afterClear | issueMask;
  end

  // Latency restarts on issue, idles at zero, and otherwise counts up to saturation.
  always_comb begin
    lat_d = lat_q;
    if (issue_i) begin
      lat_d = '0;
    end else if (!busy_o || clear_i) begin
      lat_d = '0;
    end else if (lat_q != LatMax) begin
      lat_d = lat_q + 1'b1;
    end
  end

  // Report the issue-to-clear latency and the protocol violations seen this cycle.
  always_comb begin
    retire_o         = clear_i && busy_o;
    retireLat_o      = (lat_q == LatMax) ? LatMax : (lat_q + 1'b1);
    errDoubleIssue_o = issue_i && busy_o && !clear_i;
    errClearIdle_o   = clear_i && !busy_o && !issue_i;
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= '0;
      lat_q     <= '0;
    end else begin
      pending_q <= pending_d;
      lat_q     <= lat_d;
    end
  end

endmodule

// File: rtl/vanilla_pending_op_tracker.sv
// Tracks outstanding long-latency writebacks across num_rf_p register files and
// num_cat_p categories, with per-category counts, per-RF worst latency and
// sticky protocol-error flags. Define VANILLA_PENDING_TRACKER_ASSERT_EN to get
// simulation $error messages on error events, out-of-range indices and X strobes.
module vanilla_pending_op_tracker
  import vanilla_pending_tracker_pkg::*;
#(
  parameter int num_rf_p          = 2,
  parameter int reg_els_p         = 32,
  parameter int num_cat_p         = num_pending_cat_gp,
  parameter int lat_width_p       = 16,
  parameter int reg_addr_width_lp = safeClog2(reg_els_p),
  parameter int cnt_width_lp      = bsgWidth(num_rf_p * reg_els_p),
  parameter int rf_width_lp       = safeClog2(num_rf_p),
  parameter int cat_width_lp      = safeClog2(num_cat_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    issue_v_i,
  input  logic [rf_width_lp-1:0]                  issue_rf_i,
  input  logic [reg_addr_width_lp-1:0]            issue_rd_i,
  input  logic [cat_width_lp-1:0]                 issue_cat_i,
  input  logic [num_rf_p-1:0]                     clear_v_i,
  input  logic [num_rf_p*reg_addr_width_lp-1:0]   clear_id_i,
  output logic [num_rf_p*reg_els_p*num_cat_p-1:0] pending_o,
  output logic [num_rf_p*reg_els_p-1:0]           busy_o,
  output logic [num_cat_p*cnt_width_lp-1:0]       outstanding_o,
  output logic [num_rf_p*lat_width_p-1:0]         max_lat_o,
  output logic                                    err_double_issue_o,
  output logic                                    err_clear_idle_o
);

  localparam int NumEnt = num_rf_p * reg_els_p;

  typedef logic [cnt_width_lp-1:0] cnt_t;
  typedef logic [lat_width_p-1:0]  lat_t;

  logic                          issueInRange;
  logic                          issueV;
  logic [NumEnt*num_cat_p-1:0]   entPending;
  logic [NumEnt*num_cat_p-1:0]   entRemoved;
  logic [NumEnt*num_cat_p-1:0]   entAdded;
  logic [NumEnt-1:0]             entBusy;
  logic [NumEnt-1:0]             entRetire;
  logic [NumEnt*lat_width_p-1:0] entRetireLat;
  logic [NumEnt-1:0]             entErrDouble;
  logic [NumEnt-1:0]             entErrClearIdle;

  cnt_t [num_cat_p-1:0] outstanding_q;
  cnt_t [num_cat_p-1:0] outstanding_d;
  lat_t [num_rf_p-1:0]  maxLat_q;
  lat_t [num_rf_p-1:0]  maxLat_d;
  logic                 errDouble_q;
  logic                 errClearIdle_q;

  assign issueInRange = (int'(issue_rf_i) < num_rf_p) && (int'(issue_rd_i) < reg_els_p)
                        && (int'(issue_cat_i) < num_cat_p);
  assign issueV       = issue_v_i && issueInRange;

  for (genvar r = 0; r < num_rf_p; r++) begin : gRf
    for (genvar e = 0; e < reg_els_p; e++) begin : gEnt
      localparam int Idx = r * reg_els_p + e;
      logic entIssue;
      logic entClear;

      assign entIssue = issueV && (int'(issue_rf_i) == r) && (int'(issue_rd_i) == e);
      assign entClear = clear_v_i[r]
                        && (int'(clear_id_i[r*reg_addr_width_lp +: reg_addr_width_lp]) == e);

      vanilla_pending_reg_entry #(
        .num_cat_p   (num_cat_p),
        .lat_width_p (lat_width_p)
      ) uEntry (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .issue_i          (entIssue),
        .issueCat_i       (issue_cat_i),
        .clear_i          (entClear),
        .pending_o        (entPending[Idx*num_cat_p +: num_cat_p]),
        .busy_o           (entBusy[Idx]),
        .removed_o        (entRemoved[Idx*num_cat_p +: num_cat_p]),
        .added_o          (entAdded[Idx*num_cat_p +: num_cat_p]),
        .retire_o         (entRetire[Idx]),
        .retireLat_o      (entRetireLat[Idx*lat_width_p +: lat_width_p]),
        .errDoubleIssue_o (entErrDouble[Idx]),
        .errClearIdle_o   (entErrClearIdle[Idx])
      );
    end
  end

  assign pending_o          = entPending;
  assign busy_o             = entBusy;
  assign outstanding_o      = outstanding_q;
  assign max_lat_o          = maxLat_q;
  assign err_double_issue_o = errDouble_q;
  assign err_clear_idle_o   = errClearIdle_q;

  // Per-category count follows the pending popcount: subtract every retired bit, add every new one.
  always_comb begin
    outstanding_d = outstanding_q;
    for (int c = 0; c < num_cat_p; c++) begin
      for (int i = 0; i < NumEnt; i++) begin
        outstanding_d[c] = outstanding_d[c] - cnt_t'(entRemoved[i*num_cat_p + c])
                           + cnt_t'(entAdded[i*num_cat_p + c]);
      end
    end
  end

  // Each RF retires at most one register per cycle; keep the worst latency seen.
  always_comb begin
    maxLat_d = maxLat_q;
    for (int r = 0; r < num_rf_p; r++) begin
      for (int e = 0; e < reg_els_p; e++) begin
        if (entRetire[r*reg_els_p + e]
            && (entRetireLat[(r*reg_els_p + e)*lat_width_p +: lat_width_p] > maxLat_d[r])) begin
          maxLat_d[r] = entRetireLat[(r*reg_els_p + e)*lat_width_p +: lat_width_p];
        end
      end
    end
  end

  // Aggregate state and sticky error flags, all dropped by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding_q  <= '0;
      maxLat_q       <= '0;
      errDouble_q    <= 1'b0;
      errClearIdle_q <= 1'b0;
    end else begin
      outstanding_q  <= outstanding_d;
      maxLat_q       <= maxLat_d;
      errDouble_q    <= errDouble_q | (|entErrDouble);
      errClearIdle_q <= errClearIdle_q | (|entErrClearIdle);
    end
  end

`ifdef VANILLA_PENDING_TRACKER_ASSERT_EN
  // Simulation-only diagnostics for every error event, bad index and unknown strobe.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if ($isunknown(issue_v_i) || $isunknown(clear_v_i)) begin
        $error("%0t pending tracker: X on issue_v_i/clear_v_i", $time);
      end
      if (issue_v_i && !issueInRange) begin
        $error("%0t pending tracker: out-of-range issue rf=%0d rd=%0d cat=%0d",
               $time, issue_rf_i, issue_rd_i, issue_cat_i);
      end
      if (|entErrDouble) begin
        $error("%0t pending tracker: double issue rf=%0d rd=%0d cat=%0d",
               $time, issue_rf_i, issue_rd_i, issue_cat_i);
      end
      for (int r = 0; r < num_rf_p; r++) begin
        if (clear_v_i[r]
            && (int'(clear_id_i[r*reg_addr_width_lp +: reg_addr_width_lp]) >= reg_els_p)) begin
          $error("%0t pending tracker: out-of-range clear rf=%0d rd=%0d",
                 $time, r, clear_id_i[r*reg_addr_width_lp +: reg_addr_width_lp]);
        end
        for (int e = 0; e < reg_els_p; e++) begin
          if (entErrClearIdle[r*reg_els_p + e]) begin
            $error("%0t pending tracker: clear of idle reg rf=%0d rd=%0d cat=all", $time, r, e);
          end
        end
      end
    end
  end
`else
`endif

endmodule
